// File: rtl/mem_req_queue_if.sv
// Request/response bundle between the execute-stage memory unit, the request queue and the data-cache side.
// slave: the queue's view. master: the upstream/cache environment's view.
interface mem_req_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              enq_valid_i;
    logic              enq_ready_o;
    logic              enq_is_store_i;
    logic [ADDR_W-1:0] enq_addr_i;
    logic [DATA_W-1:0] enq_data_i;
    logic [3:0]        enq_op_type_i;
    logic [TAG_W-1:0]  enq_tag_i;
    logic              deq_valid_o;
    logic              deq_ready_i;
    logic              deq_is_store_o;
    logic [ADDR_W-1:0] deq_addr_o;
    logic [DATA_W-1:0] deq_data_o;
    logic [3:0]        deq_op_type_o;
    logic [TAG_W-1:0]  deq_tag_o;
    logic              done_i;
    logic              replay_i;
    logic              flush_i;
    logic              pending_o;
    logic [CNT_W-1:0]  count_o;
    logic              full_o;
    logic              empty_o;

    modport slave (
        input  enq_valid_i, enq_is_store_i, enq_addr_i, enq_data_i, enq_op_type_i, enq_tag_i,
        input  deq_ready_i, done_i, replay_i, flush_i,
        output enq_ready_o, deq_valid_o, deq_is_store_o, deq_addr_o, deq_data_o,
        output deq_op_type_o, deq_tag_o, pending_o, count_o, full_o, empty_o
    );

    modport master (
        output enq_valid_i, enq_is_store_i, enq_addr_i, enq_data_i, enq_op_type_i, enq_tag_i,
        output deq_ready_i, done_i, replay_i, flush_i,
        input  enq_ready_o, deq_valid_o, deq_is_store_o, deq_addr_o, deq_data_o,
        input  deq_op_type_o, deq_tag_o, pending_o, count_o, full_o, empty_o
    );
endinterface

// File: rtl/mem_req_queue.sv
// In-order memory request queue: holds the issued head until done/replay, flush drops un-issued entries.
// Define MEM_REQ_QUEUE_BYPASS_EN for a zero-latency enq->deq path when the queue is empty and idle.
module mem_req_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 8
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    mem_req_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic              is_store;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        op_type;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t           r_mem [DEPTH];
    state_t           r_state, w_state_nxt;
    logic [PTR_W-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_flushed, w_flushed_nxt;
    logic             w_full, w_empty, w_enq_ready, w_push, w_pop, w_deq_valid;
    entry_t           w_enq_entry, w_deq_entry;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_enq_ready = !w_full && !bus.flush_i;
    assign w_push      = bus.enq_valid_i && w_enq_ready;
    assign w_enq_entry = '{bus.enq_is_store_i, bus.enq_addr_i, bus.enq_data_i,
                           bus.enq_op_type_i, bus.enq_tag_i};

    always_comb begin
        w_deq_valid = 1'b0;
        w_deq_entry = r_mem[r_head];
        if (r_state == IDLE) begin
            w_deq_valid = !w_empty && !bus.flush_i;
`ifdef MEM_REQ_QUEUE_BYPASS_EN
            if (w_empty && !bus.flush_i) begin
                w_deq_valid = bus.enq_valid_i;
                w_deq_entry = w_enq_entry;
            end
`endif
        end
    end

    // Head leaves only on completion, or on replay of a request whose queue was flushed under it.
    assign w_pop = (r_state == WAIT) && (bus.done_i || (bus.replay_i && r_flushed));

    always_comb begin
        w_state_nxt   = r_state;
        w_flushed_nxt = r_flushed;
        w_head_nxt    = r_head + PTR_W'(w_pop);
        w_tail_nxt    = r_tail + PTR_W'(w_push);
        w_count_nxt   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        case (r_state)
            IDLE: if (w_deq_valid && bus.deq_ready_i) w_state_nxt = WAIT;
            WAIT: if (bus.done_i || bus.replay_i) begin
                w_state_nxt   = IDLE;
                w_flushed_nxt = 1'b0;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Flush keeps only an in-flight head that is still awaiting its response.
        if (bus.flush_i) begin
            if (r_state == WAIT && !bus.done_i && !bus.replay_i) begin
                w_count_nxt   = CNT_W'(1);
                w_tail_nxt    = r_head + PTR_W'(1);
                w_flushed_nxt = 1'b1;
            end else begin
                w_count_nxt   = '0;
                w_tail_nxt    = w_head_nxt;
                w_flushed_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= IDLE;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_flushed <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_count   <= w_count_nxt;
            r_flushed <= w_flushed_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_tail] <= w_enq_entry;
    end

    assign bus.enq_ready_o    = w_enq_ready;
    assign bus.deq_valid_o    = w_deq_valid;
    assign bus.deq_is_store_o = w_deq_entry.is_store;
    assign bus.deq_addr_o     = w_deq_entry.addr;
    assign bus.deq_data_o     = w_deq_entry.data;
    assign bus.deq_op_type_o  = w_deq_entry.op_type;
    assign bus.deq_tag_o      = w_deq_entry.tag;
    assign bus.pending_o      = (r_state == WAIT);
    assign bus.count_o        = r_count;
    assign bus.full_o         = w_full;
    assign bus.empty_o        = w_empty;
endmodule
